hazard_scoreboard: RTL and testbench

- Parametrised hazard unit for the pipelined core, evaluated in ID.
- Tracks in-flight writers in a DEPTH-slot shift scoreboard: slot 0 = EX, slot 1 = MEM, slot 2 = WB for the default DEPTH=3.
- Outputs an ID stall, per-source forwarding selects, and a saturating stall-cycle counter.
- Replaces per-opcode stall tables with decoded use/write flags. Supports a forwarding and a non-forwarding mode, and optional serialisation of memory operations.

---
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: a shift scoreboard of in-flight writers (slot 0 = EX)
// drives the ID stall, per-source bypass selects and a saturating stall counter.

module hazard_scoreboard_match #(
  parameter int REG_AW = 3
) (
  input  logic              v_i,
  input  logic              wr_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic              use_i,
  output logic              hit_o
);
  assign hit_o = use_i & v_i & wr_i & (rd_i == src_i);
endmodule

module hazard_scoreboard #(
  parameter int REG_AW     = 3,
  parameter int DEPTH      = 3,
  parameter int SEL_W      = 2,
  parameter int FWD_EN     = 1,
  parameter int LOAD_LAT   = 1,
  parameter int MEM_SERIAL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic              id_rs_use_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rt_use_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_rd_wr_i,
  input  logic              id_is_load_i,
  input  logic              id_is_mem_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [SEL_W-1:0]  fwd_rs_sel_o,
  output logic [SEL_W-1:0]  fwd_rt_sel_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  if (DEPTH < 2 || (1 << SEL_W) < DEPTH + 1) begin : g_bad_cfg
    $error("hazard_scoreboard: DEPTH must be >= 2 and 2**SEL_W >= DEPTH+1");
  end

  typedef struct packed {
    logic              v;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic              ld;
    logic              mem;
  } slot_t;

  slot_t [DEPTH-1:0] sb_q, sb_d;
  logic  [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-1:0] rs_hit, rt_hit, mem_vld;
  logic             rs_any, rt_any, rs_early_ld, rt_early_ld;
  logic [SEL_W-1:0] rs_sel, rt_sel;
  logic             rs_hz, rt_hz, mem_hz, stall, issue;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    hazard_scoreboard_match #(.REG_AW(REG_AW)) u_rs (
      .v_i   (sb_q[k].v),
      .wr_i  (sb_q[k].wr),
      .rd_i  (sb_q[k].rd),
      .src_i (id_rs_i),
      .use_i (id_rs_use_i),
      .hit_o (rs_hit[k])
    );
    hazard_scoreboard_match #(.REG_AW(REG_AW)) u_rt (
      .v_i   (sb_q[k].v),
      .wr_i  (sb_q[k].wr),
      .rd_i  (sb_q[k].rd),
      .src_i (id_rt_i),
      .use_i (id_rt_use_i),
      .hit_o (rt_hit[k])
    );
    assign mem_vld[k] = sb_q[k].v & sb_q[k].mem;
  end

  // Scan oldest to youngest so the youngest matching writer is the one kept.
  always_comb begin
    rs_any      = 1'b0;
    rt_any      = 1'b0;
    rs_early_ld = 1'b0;
    rt_early_ld = 1'b0;
    rs_sel      = '0;
    rt_sel      = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs_hit[k]) begin
        rs_any      = 1'b1;
        rs_sel      = SEL_W'(k + 1);
        rs_early_ld = sb_q[k].ld & (k < LOAD_LAT);
      end
      if (rt_hit[k]) begin
        rt_any      = 1'b1;
        rt_sel      = SEL_W'(k + 1);
        rt_early_ld = sb_q[k].ld & (k < LOAD_LAT);
      end
    end
  end

  // Without a bypass network any in-flight producer blocks until it retires.
  assign rs_hz  = (FWD_EN != 0) ? rs_early_ld : rs_any;
  assign rt_hz  = (FWD_EN != 0) ? rt_early_ld : rt_any;
  assign mem_hz = (MEM_SERIAL != 0) & id_is_mem_i & (|mem_vld);
  assign stall  = id_valid_i & ~flush_i & (rs_hz | rt_hz | mem_hz);
  assign issue  = id_valid_i & ~flush_i & ~stall;

  always_comb begin
    sb_d = '0;
    for (int k = 1; k < DEPTH; k++) sb_d[k] = sb_q[k-1];
    if (issue) begin
      sb_d[0].v   = 1'b1;
      sb_d[0].wr  = id_rd_wr_i;
      sb_d[0].rd  = id_rd_i;
      sb_d[0].ld  = id_is_load_i;
      sb_d[0].mem = id_is_mem_i;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_o       = stall;
  assign fwd_rs_sel_o  = (FWD_EN != 0) ? rs_sel : '0;
  assign fwd_rt_sel_o  = (FWD_EN != 0) ? rt_sel : '0;
  assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three builds (bypass, no-bypass, 4-bit counter)
// share one stimulus stream and are each tracked by an issue-time reference model.

module tb_hazard_scoreboard;
  localparam int AW = 3, DEPTH = 3, SW = 2, LL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, vld, rsu, rtu, wr, ld, mem, fl;
  logic [AW-1:0] rs, rt, rd;
  logic          st_w  [3];
  logic [SW-1:0] rss_w [3];
  logic [SW-1:0] rts_w [3];
  logic [15:0]   cnt_w [3];
  logic [3:0]    cnt_c;
  assign cnt_w[2] = {12'd0, cnt_c};

  hazard_scoreboard #(.REG_AW(AW), .DEPTH(DEPTH), .SEL_W(SW), .FWD_EN(1), .LOAD_LAT(LL),
                      .MEM_SERIAL(1), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_i(rst), .id_valid_i(vld), .id_rs_i(rs), .id_rs_use_i(rsu),
    .id_rt_i(rt), .id_rt_use_i(rtu), .id_rd_i(rd), .id_rd_wr_i(wr), .id_is_load_i(ld),
    .id_is_mem_i(mem), .flush_i(fl), .stall_o(st_w[0]), .fwd_rs_sel_o(rss_w[0]),
    .fwd_rt_sel_o(rts_w[0]), .stall_count_o(cnt_w[0]));

  hazard_scoreboard #(.REG_AW(AW), .DEPTH(DEPTH), .SEL_W(SW), .FWD_EN(0), .LOAD_LAT(LL),
                      .MEM_SERIAL(1), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_i(rst), .id_valid_i(vld), .id_rs_i(rs), .id_rs_use_i(rsu),
    .id_rt_i(rt), .id_rt_use_i(rtu), .id_rd_i(rd), .id_rd_wr_i(wr), .id_is_load_i(ld),
    .id_is_mem_i(mem), .flush_i(fl), .stall_o(st_w[1]), .fwd_rs_sel_o(rss_w[1]),
    .fwd_rt_sel_o(rts_w[1]), .stall_count_o(cnt_w[1]));

  hazard_scoreboard #(.REG_AW(AW), .DEPTH(DEPTH), .SEL_W(SW), .FWD_EN(1), .LOAD_LAT(LL),
                      .MEM_SERIAL(1), .CNT_W(4)) u_c (
    .clk_i(clk), .rst_i(rst), .id_valid_i(vld), .id_rs_i(rs), .id_rs_use_i(rsu),
    .id_rt_i(rt), .id_rt_use_i(rtu), .id_rd_i(rd), .id_rd_wr_i(wr), .id_is_load_i(ld),
    .id_is_mem_i(mem), .flush_i(fl), .stall_o(st_w[2]), .fwd_rs_sel_o(rss_w[2]),
    .fwd_rt_sel_o(rts_w[2]), .stall_count_o(cnt_c));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d exp=%0d", name, idx, got, exp);
    end
  endtask

  // Reference model: list of issued instructions stamped with issue cycle;
  // an instruction sits in slot (cyc - t) and is gone once that reaches DEPTH.
  typedef struct { int t; int rd; bit wr; bit ld; bit mem; } rec_t;
  rec_t ml [3][8];
  int   mn [3];
  int   mc [3];
  int   cyc = 0;
  bit   chk_en = 1'b0;

  function automatic int cmax(input int d);
    return (d == 2) ? 15 : 65535;
  endfunction

  function automatic bit fwd(input int d);
    return d != 1;
  endfunction

  function automatic void src_eval(input int d, input bit u, input int src, output bit hz, output int sel);
    int best = -1;
    int s;
    hz = 1'b0;
    sel = 0;
    if (u)
      for (int i = 0; i < mn[d]; i++)
        if (ml[d][i].wr && ml[d][i].rd == src && (best < 0 || ml[d][i].t > ml[d][best].t)) best = i;
    if (best >= 0) begin
      s   = cyc - ml[d][best].t;
      hz  = fwd(d) ? (ml[d][best].ld && s < LL) : 1'b1;
      sel = fwd(d) ? s + 1 : 0;
    end
  endfunction

  function automatic void meval(input int d, output bit st, output int ss, output int ts);
    bit h1, h2, hm;
    hm = 1'b0;
    src_eval(d, rsu, int'(rs), h1, ss);
    src_eval(d, rtu, int'(rt), h2, ts);
    if (mem) for (int i = 0; i < mn[d]; i++) if (ml[d][i].mem) hm = 1'b1;
    st = vld && !fl && (h1 || h2 || hm);
  endfunction

  always @(posedge clk) begin : model
    bit mst [3];
    int a, b, k;
    for (int d = 0; d < 3; d++) meval(d, mst[d], a, b);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        mn[d] = 0;
        mc[d] = 0;
      end else begin
        if (mst[d] && mc[d] < cmax(d)) mc[d]++;
        k = 0;
        for (int i = 0; i < mn[d]; i++)
          if (cyc + 1 - ml[d][i].t < DEPTH) begin ml[d][k] = ml[d][i]; k++; end
        mn[d] = k;
        if (vld && !fl && !mst[d]) begin
          ml[d][mn[d]] = '{cyc + 1, int'(rd), wr, ld, mem};
          mn[d]++;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : auto_chk
    bit s;
    int a, b;
    if (chk_en)
      for (int d = 0; d < 3; d++) begin
        meval(d, s, a, b);
        chk("model_stall", d, 32'(st_w[d]), 32'(s));
        if (!s) begin
          chk("model_rs_sel", d, 32'(rss_w[d]), a);
          chk("model_rt_sel", d, 32'(rts_w[d]), b);
        end
        chk("model_count", d, 32'(cnt_w[d]), mc[d]);
      end
  end

  task automatic drive(input bit r, input bit v, input int s1, input bit u1, input int s2, input bit u2,
                       input int d_, input bit w, input bit l, input bit m, input bit f);
    rst = r; vld = v; rs = s1[AW-1:0]; rsu = u1; rt = s2[AW-1:0]; rtu = u2;
    rd = d_[AW-1:0]; wr = w; ld = l; mem = m; fl = f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit r, v; int s1; bit u1; int s2; bit u2; int d; bit w, l, m, f;
    bit es; int ers, ert, ec;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, int s1, bit u1, int s2, bit u2, int d, bit w, bit l,
                              bit m, bit f, bit es, int ers, int ert, int ec);
    vec_t x;
    x = '{r, v, s1, u1, s2, u2, d, w, l, m, f, es, ers, ert, ec};
    return x;
  endfunction

  localparam int NV = 23;
  vec_t tv [NV];

  initial begin
    //        r  v  rs u  rt u  rd w  l  m  f   st rs rt cnt   (expectations for the bypass build)
    tv[0]  = mk(0, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tv[1]  = mk(0, 1, 3, 1, 4, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0);
    tv[2]  = mk(0, 1, 1, 1, 1, 1, 5, 1, 0, 0, 0,  0, 1, 1, 0);
    tv[3]  = mk(0, 1, 1, 1, 0, 0, 6, 1, 0, 0, 0,  0, 2, 0, 0);
    tv[4]  = mk(0, 1, 0, 0, 0, 0, 2, 1, 1, 1, 0,  0, 0, 0, 0);
    tv[5]  = mk(0, 1, 7, 1, 2, 1, 3, 1, 0, 0, 0,  1, 0, 0, 0);
    tv[6]  = mk(0, 1, 7, 1, 2, 1, 3, 1, 0, 0, 0,  0, 0, 2, 1);
    tv[7]  = mk(0, 1, 0, 0, 0, 0, 4, 1, 1, 1, 0,  1, 0, 0, 1);
    tv[8]  = mk(0, 1, 0, 0, 0, 0, 4, 1, 1, 1, 0,  0, 0, 0, 2);
    tv[9]  = mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  0, 0, 0, 2);
    tv[10] = mk(0, 1, 4, 1, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 2);
    tv[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2);
    tv[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2);
    tv[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2);
    tv[14] = mk(0, 1, 1, 1, 2, 1, 0, 0, 0, 1, 0,  0, 0, 0, 2);
    tv[15] = mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 1, 1,  0, 0, 0, 2);
    tv[16] = mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 1, 0,  1, 0, 0, 2);
    tv[17] = mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 1, 0,  1, 0, 0, 3);
    tv[18] = mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 1, 0,  0, 0, 0, 4);
    tv[19] = mk(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  0, 0, 0, 4);
    tv[20] = mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 0, 4);
    tv[21] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4);
    tv[22] = mk(0, 1, 5, 1, 7, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) next_cycle();
    chk_en = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].r, tv[i].v, tv[i].s1, tv[i].u1, tv[i].s2, tv[i].u2, tv[i].d,
            tv[i].w, tv[i].l, tv[i].m, tv[i].f);
      @(negedge clk);
      chk("tv_stall", i, 32'(st_w[0]), 32'(tv[i].es));
      if (!tv[i].es) begin
        chk("tv_rs_sel", i, 32'(rss_w[0]), tv[i].ers);
        chk("tv_rt_sel", i, 32'(rts_w[0]), tv[i].ert);
      end
      chk("tv_count", i, 32'(cnt_w[0]), tv[i].ec);
      next_cycle();
    end

    // No-bypass build: reader of an ALU result waits until the writer retires.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    @(negedge clk);
    chk("nofwd_producer_stall", 0, 32'(st_w[1]), 0);
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      drive(0, 1, 3, 1, 0, 0, 6, 1, 0, 0, 0);
      @(negedge clk);
      chk("nofwd_reader_stall", c, 32'(st_w[1]), (c < 4) ? 1 : 0);
      if (c == 4) begin
        chk("nofwd_issue_sel", c, 32'(rss_w[1]), 0);
        chk("nofwd_count", c, 32'(cnt_w[1]), 3);
      end
      next_cycle();
    end

    // Back-to-back loads under memory serialisation; 4-bit counter saturates.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    for (int c = 0; c < 40; c++) begin
      drive(0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0);
      @(negedge clk);
      if (c < 8) chk("serial_stall", c, 32'(st_w[0]), (c % 4 != 0) ? 1 : 0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat_count_c", 0, 32'(cnt_w[2]), 15);
    chk("wide_count_a", 0, 32'(cnt_w[0]), 30);
    next_cycle();

    for (int c = 0; c < 3000; c++) begin
      bit l, m, w;
      l = ($urandom_range(0, 2) == 0);
      m = l || ($urandom_range(0, 3) == 0);
      w = l || ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
            int'($urandom_range(0, 7)), w, l, m, $urandom_range(0, 7) == 0);
      next_cycle();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
